// File: rtl/conv_pkg.sv
// Shared definitions for the convolution sequencer: FSM state encoding and
// the signed 18-bit saturation limits applied to every written result.
package conv_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD_IMG = 3'd1,
        RD_FLT = 3'd2,
        MAC    = 3'd3,
        WRITE  = 3'd4,
        FINISH = 3'd5
    } state_t;

    localparam int     DATA_W  = 18;
    localparam longint SAT_MAX = 131071;
    localparam longint SAT_MIN = -131072;

    function automatic logic signed [DATA_W-1:0] sat_data(input longint v);
        logic signed [DATA_W-1:0] r;
        if (v > SAT_MAX)
            r = DATA_W'(SAT_MAX);
        else if (v < SAT_MIN)
            r = DATA_W'(SAT_MIN);
        else
            r = DATA_W'(v);
        return r;
    endfunction

endpackage

// File: rtl/conv_addr_gen.sv
// Read-address generator: turns the window/tap counters for the upcoming
// read into a registered image or filter address (wraps modulo 2^ADDR_W).
module conv_addr_gen #(
    parameter int ADDR_W = 16
) (
    input  logic              master_clk,
    input  logic              rst,
    input  logic              load,
    input  logic              sel_flt,
    input  logic [ADDR_W-1:0] img_base,
    input  logic [ADDR_W-1:0] flt_base,
    input  logic [7:0]        dim,
    input  logic [2:0]        k,
    input  logic [8:0]        d,
    input  logic [7:0]        y_pos,
    input  logic [7:0]        x_pos,
    input  logic [2:0]        ky,
    input  logic [2:0]        kx,
    output logic [ADDR_W-1:0] rd_addr
);

    logic [31:0] img_lin;
    logic [31:0] flt_lin;

    always_comb begin
        img_lin = (32'(d) * 32'(dim) + 32'(y_pos) + 32'(ky)) * 32'(dim) + 32'(x_pos) + 32'(kx);
        flt_lin = (32'(d) * 32'(k) + 32'(ky)) * 32'(k) + 32'(kx);
    end

    always_ff @(posedge master_clk) begin
        if (rst)
            rd_addr <= '0;
        else if (load)
            rd_addr <= sel_flt ? flt_base + flt_lin[ADDR_W-1:0]
                               : img_base + img_lin[ADDR_W-1:0];
    end

endmodule

// File: rtl/conv_sequencer.sv
// Convolution sequencer: walks output windows and taps over a shared read
// port, accumulates products and writes saturated results. Define
// CONV_SEQ_RELU_EN to clamp negative results to zero.
module conv_sequencer
    import conv_pkg::*;
#(
    parameter int ACC_W  = 40,
    parameter int ADDR_W = 16
) (
    input  logic                     master_clk,
    input  logic                     rst,
    input  logic                     trigger_accel,
    input  logic [7:0]               image_dim,
    input  logic [8:0]               image_depth,
    input  logic [ADDR_W-1:0]        image_memory_offset,
    input  logic [ADDR_W-1:0]        filter_memory_offset,
    input  logic [ADDR_W-1:0]        output_memory_offset,
    input  logic [1:0]               filter_halfsize,
    input  logic [2:0]               filter_stride,
    input  logic signed [DATA_W-1:0] filter_bias,
    output logic [ADDR_W-1:0]        rd_addr,
    output logic                     rd_en,
    input  logic signed [DATA_W-1:0] rd_data,
    output logic [ADDR_W-1:0]        wr_addr,
    output logic signed [DATA_W-1:0] wr_data,
    output logic                     wr_en,
    output logic                     busy,
    output logic                     done
);

    state_t state, state_nxt;

    logic [7:0]               cfg_dim, cfg_dim_nxt;
    logic [8:0]               cfg_depth, cfg_depth_nxt;
    logic [2:0]               cfg_k, cfg_k_nxt;
    logic [2:0]               cfg_stride, cfg_stride_nxt;
    logic [ADDR_W-1:0]        cfg_img_off, cfg_img_off_nxt;
    logic [ADDR_W-1:0]        cfg_flt_off, cfg_flt_off_nxt;
    logic [ADDR_W-1:0]        cfg_out_off, cfg_out_off_nxt;
    logic signed [DATA_W-1:0] cfg_bias, cfg_bias_nxt;

    logic [8:0]               d_cnt, d_nxt;
    logic [2:0]               ky_cnt, ky_nxt, kx_cnt, kx_nxt;
    logic [7:0]               y_pos, y_nxt, x_pos, x_nxt;
    logic [ADDR_W-1:0]        out_idx, out_idx_nxt;
    logic signed [ACC_W-1:0]  acc, acc_nxt;
    logic signed [DATA_W-1:0] pixel;
    logic signed [35:0]       product;

    logic [2:0]               k_live;
    logic                     accept, degenerate, last_tap, last_col, last_row;
    logic [9:0]               x_end, y_end;
    logic signed [DATA_W-1:0] sat_val, wr_value;

    // NOTE: every always_comb output is assigned a default first so no latch is inferred.
    always_comb begin
        k_live     = {filter_halfsize, 1'b1};
        degenerate = (image_dim < {5'd0, k_live}) || (image_depth == '0);
        accept     = (state == IDLE) && trigger_accel;

        cfg_dim_nxt     = accept ? image_dim : cfg_dim;
        cfg_depth_nxt   = accept ? image_depth : cfg_depth;
        cfg_k_nxt       = accept ? k_live : cfg_k;
        cfg_stride_nxt  = accept ? ((filter_stride == '0) ? 3'd1 : filter_stride) : cfg_stride;
        cfg_img_off_nxt = accept ? image_memory_offset : cfg_img_off;
        cfg_flt_off_nxt = accept ? filter_memory_offset : cfg_flt_off;
        cfg_out_off_nxt = accept ? output_memory_offset : cfg_out_off;
        cfg_bias_nxt    = accept ? filter_bias : cfg_bias;

        product  = pixel * rd_data;
        last_tap = (kx_cnt == cfg_k - 3'd1) && (ky_cnt == cfg_k - 3'd1)
                && (d_cnt == cfg_depth - 9'd1);
        // A window is the last in its row/column when the next one would overhang the image.
        x_end    = {2'b0, x_pos} + {7'b0, cfg_stride} + {7'b0, cfg_k};
        y_end    = {2'b0, y_pos} + {7'b0, cfg_stride} + {7'b0, cfg_k};
        last_col = x_end > {2'b0, cfg_dim};
        last_row = y_end > {2'b0, cfg_dim};

        state_nxt   = state;
        d_nxt       = d_cnt;
        ky_nxt      = ky_cnt;
        kx_nxt      = kx_cnt;
        y_nxt       = y_pos;
        x_nxt       = x_pos;
        out_idx_nxt = out_idx;
        acc_nxt     = acc;

        case (state)
            IDLE: begin
                if (trigger_accel) begin
                    state_nxt   = degenerate ? FINISH : RD_IMG;
                    d_nxt       = '0;
                    ky_nxt      = '0;
                    kx_nxt      = '0;
                    y_nxt       = '0;
                    x_nxt       = '0;
                    out_idx_nxt = '0;
                    acc_nxt     = '0;
                end
            end
            RD_IMG: state_nxt = RD_FLT;
            RD_FLT: state_nxt = MAC;
            MAC: begin
                acc_nxt = acc + ACC_W'(product);
                if (last_tap) begin
                    state_nxt = WRITE;
                end else begin
                    state_nxt = RD_IMG;
                    if (kx_cnt != cfg_k - 3'd1) begin
                        kx_nxt = kx_cnt + 3'd1;
                    end else begin
                        kx_nxt = '0;
                        if (ky_cnt != cfg_k - 3'd1) begin
                            ky_nxt = ky_cnt + 3'd1;
                        end else begin
                            ky_nxt = '0;
                            d_nxt  = d_cnt + 9'd1;
                        end
                    end
                end
            end
            WRITE: begin
                acc_nxt     = '0;
                d_nxt       = '0;
                ky_nxt      = '0;
                kx_nxt      = '0;
                out_idx_nxt = out_idx + 1'b1;
                if (last_col && last_row) begin
                    state_nxt = FINISH;
                end else begin
                    state_nxt = RD_IMG;
                    if (!last_col) begin
                        x_nxt = x_pos + {5'd0, cfg_stride};
                    end else begin
                        x_nxt = '0;
                        y_nxt = y_pos + {5'd0, cfg_stride};
                    end
                end
            end
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        sat_val = sat_data(longint'(acc_nxt) + longint'(cfg_bias));
`ifdef CONV_SEQ_RELU_EN
        wr_value = sat_val[DATA_W-1] ? '0 : sat_val;
`else
        wr_value = sat_val;
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge master_clk) begin
        if (rst) begin
            state       <= IDLE;
            cfg_dim     <= '0;
            cfg_depth   <= '0;
            cfg_k       <= '0;
            cfg_stride  <= '0;
            cfg_img_off <= '0;
            cfg_flt_off <= '0;
            cfg_out_off <= '0;
            cfg_bias    <= '0;
            d_cnt       <= '0;
            ky_cnt      <= '0;
            kx_cnt      <= '0;
            y_pos       <= '0;
            x_pos       <= '0;
            out_idx     <= '0;
            acc         <= '0;
            pixel       <= '0;
            rd_en       <= 1'b0;
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_nxt;
            cfg_dim     <= cfg_dim_nxt;
            cfg_depth   <= cfg_depth_nxt;
            cfg_k       <= cfg_k_nxt;
            cfg_stride  <= cfg_stride_nxt;
            cfg_img_off <= cfg_img_off_nxt;
            cfg_flt_off <= cfg_flt_off_nxt;
            cfg_out_off <= cfg_out_off_nxt;
            cfg_bias    <= cfg_bias_nxt;
            d_cnt       <= d_nxt;
            ky_cnt      <= ky_nxt;
            kx_cnt      <= kx_nxt;
            y_pos       <= y_nxt;
            x_pos       <= x_nxt;
            out_idx     <= out_idx_nxt;
            acc         <= acc_nxt;
            if (state == RD_FLT)
                pixel <= rd_data;
            rd_en <= (state_nxt == RD_IMG) || (state_nxt == RD_FLT);
            wr_en <= (state_nxt == WRITE);
            done  <= (state_nxt == FINISH);
            busy  <= state_nxt inside {RD_IMG, RD_FLT, MAC, WRITE};
            if (state_nxt == WRITE) begin
                wr_addr <= cfg_out_off + out_idx;
                wr_data <= wr_value;
            end
        end
    end

    conv_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
        .master_clk (master_clk),
        .rst        (rst),
        .load       ((state_nxt == RD_IMG) || (state_nxt == RD_FLT)),
        .sel_flt    (state_nxt == RD_FLT),
        .img_base   (cfg_img_off_nxt),
        .flt_base   (cfg_flt_off_nxt),
        .dim        (cfg_dim_nxt),
        .k          (cfg_k_nxt),
        .d          (d_nxt),
        .y_pos      (y_nxt),
        .x_pos      (x_nxt),
        .ky         (ky_nxt),
        .kx         (kx_nxt),
        .rd_addr    (rd_addr)
    );

endmodule

// File: tb/tb_conv_sequencer.sv
// Scoreboard bench for conv_sequencer: a reference convolution pushes the
// expected writes, a negedge monitor pops and compares them as they appear.
module tb_conv_sequencer;

    logic               master_clk = 1'b0;
    logic               rst = 1'b1;
    logic               trigger_accel = 1'b0;
    logic [7:0]         image_dim = '0;
    logic [8:0]         image_depth = '0;
    logic [15:0]        image_memory_offset = '0;
    logic [15:0]        filter_memory_offset = '0;
    logic [15:0]        output_memory_offset = '0;
    logic [1:0]         filter_halfsize = '0;
    logic [2:0]         filter_stride = '0;
    logic signed [17:0] filter_bias = '0;
    logic [15:0]        rd_addr;
    logic               rd_en;
    logic signed [17:0] rd_data = '0;
    logic [15:0]        wr_addr;
    logic signed [17:0] wr_data;
    logic               wr_en;
    logic               busy;
    logic               done;

    conv_sequencer #(.ACC_W(40), .ADDR_W(16)) dut (
        .master_clk           (master_clk),
        .rst                  (rst),
        .trigger_accel        (trigger_accel),
        .image_dim            (image_dim),
        .image_depth          (image_depth),
        .image_memory_offset  (image_memory_offset),
        .filter_memory_offset (filter_memory_offset),
        .output_memory_offset (output_memory_offset),
        .filter_halfsize      (filter_halfsize),
        .filter_stride        (filter_stride),
        .filter_bias          (filter_bias),
        .rd_addr              (rd_addr),
        .rd_en                (rd_en),
        .rd_data              (rd_data),
        .wr_addr              (wr_addr),
        .wr_data              (wr_data),
        .wr_en                (wr_en),
        .busy                 (busy),
        .done                 (done)
    );

    always #5 master_clk = ~master_clk;

    logic [17:0] mem [0:65535];
    always @(posedge master_clk)
        if (rd_en) rd_data <= mem[rd_addr];

    int cyc = 0;
    always @(posedge master_clk) cyc <= cyc + 1;

    int     total = 0;
    int     bad = 0;
    int     exp_addr_q[$];
    longint exp_data_q[$];
    int     wr_seen = 0, rd_seen = 0, unexp_wr = 0, overlap = 0;
    int     done_seen = 0, done_wide = 0, last_wr_cyc = 0;
    logic   done_prev = 1'b0;

    task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    always @(negedge master_clk) begin
        if (rd_en && wr_en) overlap++;
        if (done && done_prev) done_wide++;
        done_prev = done;
        if (done) done_seen++;
        if (rd_en) rd_seen++;
        if (wr_en) begin
            wr_seen++;
            last_wr_cyc = cyc;
            if (exp_addr_q.size() == 0) begin
                unexp_wr++;
            end else begin
                check("wr_addr", wr_addr, exp_addr_q.pop_front());
                check("wr_data", wr_data, exp_data_q.pop_front());
            end
        end
    end

    function automatic longint sx(input logic [17:0] v);
        logic signed [17:0] s;
        s = v;
        return longint'(s);
    endfunction

    task automatic fill(input int base, input int n, input int lo, input int hi);
        for (int i = 0; i < n; i++) begin
            int v;
            v = lo + int'($urandom_range(hi - lo));
            mem[(base + i) & 'hFFFF] = v[17:0];
        end
    endtask

    // Reference valid convolution; returns number of outputs and taps per output.
    task automatic push_expected(input int dim, input int depth, input int h, input int stride,
                                 input int img_off, input int flt_off, input int out_off, input int bias,
                                 output int n_out, output int taps);
        int k, s, o;
        longint acc, v;
        k = 2 * h + 1;
        s = (stride == 0) ? 1 : stride;
        n_out = 0;
        taps = depth * k * k;
        if (dim < k || depth == 0) return;
        o = (dim - k) / s + 1;
        for (int oy = 0; oy < o; oy++) begin
            for (int ox = 0; ox < o; ox++) begin
                acc = 0;
                for (int d = 0; d < depth; d++)
                    for (int ky = 0; ky < k; ky++)
                        for (int kx = 0; kx < k; kx++)
                            acc += sx(mem[(img_off + (d * dim + oy * s + ky) * dim + ox * s + kx) & 'hFFFF])
                                 * sx(mem[(flt_off + (d * k + ky) * k + kx) & 'hFFFF]);
                v = acc + bias;
                if (v > 131071) v = 131071;
                else if (v < -131072) v = -131072;
`ifdef CONV_SEQ_RELU_EN
                if (v < 0) v = 0;
`endif
                exp_addr_q.push_back((out_off + oy * o + ox) & 'hFFFF);
                exp_data_q.push_back(v);
                n_out++;
            end
        end
    endtask

    task automatic run_job(input string tag, input int dim, input int depth, input int h, input int stride,
                           input int img_off, input int flt_off, input int out_off, input int bias,
                           input int exp_wr_cyc, input int disturb_at);
        int n_out, taps, start, wr0, rd0, done_cyc, exp_done;
        bit seen;
        @(negedge master_clk);
        image_dim            = dim[7:0];
        image_depth          = depth[8:0];
        filter_halfsize      = h[1:0];
        filter_stride        = stride[2:0];
        image_memory_offset  = img_off[15:0];
        filter_memory_offset = flt_off[15:0];
        output_memory_offset = out_off[15:0];
        filter_bias          = bias[17:0];
        push_expected(dim, depth, h, stride, img_off, flt_off, out_off, bias, n_out, taps);
        exp_done = (n_out == 0) ? 1 : n_out * (3 * taps + 1) + 1;
        wr0 = wr_seen;
        rd0 = rd_seen;
        trigger_accel = 1'b1;
        start = cyc;
        seen = 0;
        done_cyc = 0;
        for (int i = 0; i < 20000 && !seen; i++) begin
            @(negedge master_clk);
            if (i == 0) begin
                trigger_accel = 1'b0;
                check({tag, "_busy"}, busy, (n_out > 0));
            end
            if (disturb_at > 0 && i == disturb_at) begin
                trigger_accel        = 1'b1;
                image_dim            = 8'd9;
                filter_halfsize      = 2'd0;
                image_memory_offset  = 16'h0F0F;
                output_memory_offset = 16'h7777;
                filter_bias          = 18'sd1000;
            end
            if (disturb_at > 0 && i == disturb_at + 1) trigger_accel = 1'b0;
            if (done) begin
                seen = 1;
                done_cyc = cyc - start;
            end
        end
        trigger_accel = 1'b0;
        check({tag, "_done"}, seen, 1);
        check({tag, "_done_cyc"}, done_cyc, exp_done);
        check({tag, "_busy_at_done"}, busy, 0);
        check({tag, "_nwr"}, wr_seen - wr0, n_out);
        check({tag, "_pending"}, exp_addr_q.size(), 0);
        if (n_out == 0) check({tag, "_nrd"}, rd_seen - rd0, 0);
        if (exp_wr_cyc > 0) check({tag, "_wr_cyc"}, last_wr_cyc - start, exp_wr_cyc);
        exp_addr_q.delete();
        exp_data_q.delete();
        @(negedge master_clk);
        check({tag, "_done_pulse"}, done, 0);
    endtask

    initial begin
        int wr0, dn0;
        for (int i = 0; i < 65536; i++) mem[i] = '0;

        repeat (3) @(negedge master_clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rd_en", rd_en, 0);
        check("rst_wr_en", wr_en, 0);
        check("rst_rd_addr", rd_addr, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        rst = 1'b0;

        fill(0, 9, 1, 1);
        fill('h100, 9, 1, 1);
        run_job("basic", 3, 1, 1, 1, 0, 'h100, 'h200, 0, 28, 0);

        fill(0, 50, 2, 2);
        fill('h100, 18, -1, -1);
        run_job("stride2", 5, 2, 1, 2, 0, 'h100, 'h400, 5, 0, 0);

        fill(0, 9, 131071, 131071);
        fill('h100, 9, 131071, 131071);
        run_job("sat_pos", 3, 1, 1, 1, 0, 'h100, 'h500, 0, 0, 0);
        fill('h100, 9, -131071, -131071);
        run_job("sat_neg", 3, 1, 1, 1, 0, 'h100, 'h500, 0, 0, 0);

        fill('hFFF8, 72, -100, 100);
        fill('h2000, 18, -20, 20);
        run_job("rand_wrap", 6, 2, 1, 0, 'hFFF8, 'h2000, 'h3000, -300, 0, 0);

        fill('h1000, 147, -500, 500);
        fill('h2000, 3, -50, 50);
        run_job("k1_s3", 7, 3, 0, 3, 'h1000, 'h2000, 'h3100, 77, 0, 0);

        fill('h1000, 64, -300, 300);
        fill('h2000, 25, -30, 30);
        run_job("k5", 8, 1, 2, 1, 'h1000, 'h2000, 'h3200, -5, 0, 0);

        run_job("degen_dim", 2, 1, 1, 1, 0, 'h100, 'h600, 0, 0, 0);
        run_job("degen_depth", 5, 0, 1, 1, 0, 'h100, 'h600, 0, 0, 0);

        fill(0, 9, -40, 40);
        fill('h100, 9, -40, 40);
        run_job("retrig", 3, 1, 1, 1, 0, 'h100, 'h200, 0, 28, 10);

        // Abort a running job with rst and confirm it leaves no trace.
        @(negedge master_clk);
        image_dim = 8'd5; image_depth = 9'd2; filter_halfsize = 2'd1; filter_stride = 3'd1;
        image_memory_offset = '0; filter_memory_offset = 16'h0100; output_memory_offset = 16'h0700;
        trigger_accel = 1'b1;
        @(negedge master_clk);
        trigger_accel = 1'b0;
        repeat (20) @(negedge master_clk);
        wr0 = wr_seen;
        dn0 = done_seen;
        rst = 1'b1;
        @(negedge master_clk);
        check("abort_busy", busy, 0);
        check("abort_rd_en", rd_en, 0);
        check("abort_rd_addr", rd_addr, 0);
        check("abort_done", done, 0);
        rst = 1'b0;
        repeat (150) @(negedge master_clk);
        check("abort_no_wr", wr_seen - wr0, 0);
        check("abort_no_done", done_seen - dn0, 0);

        fill(0, 9, -40, 40);
        fill('h100, 9, -40, 40);
        run_job("after_rst", 3, 1, 1, 1, 0, 'h100, 'h200, 3, 28, 0);

        check("rd_wr_overlap", overlap, 0);
        check("done_wide", done_wide, 0);
        check("unexpected_wr", unexp_wr, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
